// File: rtl/sram_arb_pkg.sv
// Shared widths and types for the scratchpad SRAM arbiter.
// One request record describes everything a port drives towards the SRAM.
package sram_arb_pkg;

    localparam int SRAM_AW  = 13;
    localparam int SRAM_DW  = 32;
    localparam int SRAM_BEW = 4;
    localparam int WAIT_W   = 4;

    typedef struct packed {
        logic                we;
        logic [SRAM_BEW-1:0] be;
        logic [SRAM_AW-1:0]  addr;
        logic [SRAM_DW-1:0]  wdata;
    } sram_req_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } arb_port_e;

    localparam sram_req_t SRAM_REQ_IDLE = '0;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Counts consecutive lost DMA arbitrations and flags when DMA must win once.
// The count is frozen while the SRAM is unavailable so blocking never ages a request.
module sram_arb_starve_cnt
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic avail,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    always_comb begin
        wait_nxt = wait_cnt;
        if (avail) begin
            if (dma_gnt || !dma_req) begin
                wait_nxt = '0;
            end else if (wait_cnt < LIMIT) begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    assign force_dma = (wait_cnt == LIMIT) && dma_req;

endmodule

// File: rtl/sram_arbiter.sv
// Shares the scratchpad SRAM controller between the CPU LSU and the DMA engine:
// fixed CPU priority, bounded DMA starvation, and a one-cycle read return path.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [SRAM_BEW-1:0] cpu_be,
    input  logic [SRAM_AW-1:0]  cpu_addr,
    input  logic [SRAM_DW-1:0]  cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [SRAM_DW-1:0]  cpu_rdata,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [SRAM_BEW-1:0] dma_be,
    input  logic [SRAM_AW-1:0]  dma_addr,
    input  logic [SRAM_DW-1:0]  dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [SRAM_DW-1:0]  dma_rdata,

    output logic                sram_req,
    output logic                sram_we,
    output logic [SRAM_BEW-1:0] sram_be,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_wdata,
    input  logic [SRAM_DW-1:0]  sram_rdata,

    input  logic                mbist_en,
    input  logic                ret_en,
    input  logic                pd_en,
    output logic                starve_evt
);

    logic      avail_q;
    logic      force_dma;
    logic      grant_any;
    arb_port_e winner;
    sram_req_t cpu_bus;
    sram_req_t dma_bus;
    sram_req_t sel_bus;
    logic [1:0] rd_owner_q;
    logic       starve_evt_q;

    // Mode controls act one cycle late, so a grant in the cycle a block arrives still completes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q <= 1'b0;
        end else begin
            avail_q <= pd_en & ~ret_en & ~mbist_en;
        end
    end

    sram_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .avail     (avail_q),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    assign cpu_bus = '{we: cpu_we, be: cpu_be, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_bus = '{we: dma_we, be: dma_be, addr: dma_addr, wdata: dma_wdata};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_any = 1'b0;
        winner    = PORT_CPU;
        if (avail_q) begin
            if (force_dma) begin
                grant_any = 1'b1;
                winner    = PORT_DMA;
            end else if (cpu_req) begin
                grant_any = 1'b1;
                winner    = PORT_CPU;
            end else if (dma_req) begin
                grant_any = 1'b1;
                winner    = PORT_DMA;
            end
        end
    end

    assign cpu_gnt = grant_any && (winner == PORT_CPU);
    assign dma_gnt = grant_any && (winner == PORT_DMA);

    // Idle cycles drive an all-zero command so the controller never sees stale fields.
    always_comb begin
        sel_bus = SRAM_REQ_IDLE;
        if (grant_any) begin
            sel_bus = (winner == PORT_DMA) ? dma_bus : cpu_bus;
        end
    end

    assign sram_req   = grant_any;
    assign sram_we    = sel_bus.we;
    assign sram_be    = sel_bus.be;
    assign sram_addr  = sel_bus.addr;
    assign sram_wdata = sel_bus.wdata;

    // The controller returns read data one cycle after the grant; remember who asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q   <= '0;
            starve_evt_q <= 1'b0;
        end else begin
            rd_owner_q   <= {dma_gnt & ~dma_we, cpu_gnt & ~cpu_we};
            starve_evt_q <= force_dma & avail_q;
        end
    end

    assign cpu_rvalid = rd_owner_q[PORT_CPU];
    assign dma_rvalid = rd_owner_q[PORT_DMA];
    assign cpu_rdata  = cpu_rvalid ? sram_rdata : '0;
    assign dma_rdata  = dma_rvalid ? sram_rdata : '0;
    assign starve_evt = starve_evt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed tables and sequences, then random
// traffic compared against a request-level reference model with its own memory image.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [3:0]  cpu_be, dma_be;
    logic [12:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        sram_req, sram_we;
    logic [3:0]  sram_be;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        mbist_en, ret_en, pd_en, starve_evt;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .sram_req(sram_req), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .mbist_en(mbist_en), .ret_en(ret_en), .pd_en(pd_en), .starve_evt(starve_evt)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)  return 32'h1111_1111;
        if (i == 1)  return 32'h2222_2222;
        if (i == 64) return 32'h0000_0000;
        return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000;
    endfunction

    // SRAM controller model: registered read data, byte-lane writes.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (sram_req) begin
            if (sram_we) begin
                w = mem[sram_addr[12:2]];
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[sram_addr[12:2]] <= w;
            end else begin
                sram_rdata <= mem[sram_addr[12:2]];
            end
        end
    end

    // Reference model state, request-level.
    logic [31:0] ref_mem [0:2047];
    int          lost;
    bit          exp_avail, pend_c, pend_d, pend_starve, last_cg, last_dg;
    logic [31:0] pend_data;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [12:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [3:0] be,
                           input logic [12:0] addr, input logic [31:0] wd);
        dma_req = req; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wd;
    endtask

    task automatic model_reset();
        lost = 0; exp_avail = 1'b0; pend_c = 1'b0; pend_d = 1'b0; pend_starve = 1'b0;
        last_cg = 1'b0; last_dg = 1'b0;
    endtask

    // Called mid-cycle: compare every output with the model, then advance the model.
    task automatic model_check();
        bit          forced, cg, dg, we;
        logic [3:0]  be;
        logic [12:0] a;
        logic [31:0] wd, w;
        forced = exp_avail && dma_req && (lost == LIMIT);
        cg = exp_avail && !forced && cpu_req;
        dg = exp_avail && dma_req && !cg;
        we = 1'b0; be = '0; a = '0; wd = '0;
        if (cg) begin we = cpu_we; be = cpu_be; a = cpu_addr; wd = cpu_wdata; end
        if (dg) begin we = dma_we; be = dma_be; a = dma_addr; wd = dma_wdata; end
        check("cpu_gnt", cpu_gnt, cg);
        check("dma_gnt", dma_gnt, dg);
        check("sram_req", sram_req, cg | dg);
        check("sram_we", sram_we, we);
        check("sram_be", sram_be, be);
        check("sram_addr", sram_addr, a);
        check("sram_wdata", sram_wdata, wd);
        check("cpu_rvalid", cpu_rvalid, pend_c);
        check("dma_rvalid", dma_rvalid, pend_d);
        check("cpu_rdata", cpu_rdata, pend_c ? pend_data : 32'h0);
        check("dma_rdata", dma_rdata, pend_d ? pend_data : 32'h0);
        check("starve_evt", starve_evt, pend_starve);
        pend_c = cg && !cpu_we;
        pend_d = dg && !dma_we;
        if ((cg || dg) && !we) pend_data = ref_mem[a[12:2]];
        if ((cg || dg) && we) begin
            w = ref_mem[a[12:2]];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a[12:2]] = w;
        end
        pend_starve = forced;
        if (exp_avail) begin
            if (dg || !dma_req) lost = 0;
            else if (lost < LIMIT) lost++;
        end
        exp_avail = pd_en && !ret_en && !mbist_en;
        last_cg = cg;
        last_dg = dg;
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_gnt"}, cpu_gnt, 0);
        check({tag, "_dma_gnt"}, dma_gnt, 0);
        check({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        check({tag, "_dma_rvalid"}, dma_rvalid, 0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 0);
        check({tag, "_dma_rdata"}, dma_rdata, 0);
        check({tag, "_sram_req"}, sram_req, 0);
        check({tag, "_sram_we"}, sram_we, 0);
        check({tag, "_sram_be"}, sram_be, 0);
        check({tag, "_sram_addr"}, sram_addr, 0);
        check({tag, "_sram_wdata"}, sram_wdata, 0);
        check({tag, "_starve_evt"}, starve_evt, 0);
    endtask

    typedef struct {
        bit c_req, d_req, mbist;
        bit e_cg, e_dg, e_starve;
    } vec_t;
    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Contention with STARVE_LIMIT = 4, then an MBIST window that must freeze the wait count.
        tbl = '{
            '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0},
            '{1,1,0, 0,1,0}, '{1,1,0, 1,0,1}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0},
            '{1,1,0, 1,0,0}, '{1,1,0, 0,1,0}, '{1,1,0, 1,0,1}, '{1,1,1, 1,0,0},
            '{1,1,1, 0,0,0}, '{1,1,1, 0,0,0}, '{1,1,0, 0,0,0}, '{1,1,0, 1,0,0},
            '{1,1,0, 1,0,0}, '{1,1,0, 0,1,0}, '{1,1,0, 1,0,1}
        };
        for (int i = 0; i < 2048; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        model_reset();
        mbist_en = 1'b0; ret_en = 1'b0; pd_en = 1'b1;
        set_cpu(1, 0, 4'hF, 13'h0010, 0);
        set_dma(1, 0, 4'hF, 13'h0014, 0);

        // Reset state, with both ports requesting.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        set_cpu(0, 0, 4'hF, 13'h0010, 0);
        set_dma(0, 0, 4'hF, 13'h0014, 0);
        #4; finish_cycle();

        // Single CPU write then read.
        set_cpu(1, 1, 4'hF, 13'h0040, 32'hDEAD_BEEF);
        #4; check("t1_wr_gnt", cpu_gnt, 1); finish_cycle();
        set_cpu(1, 0, 4'hF, 13'h0040, 0);
        #4; check("t1_rd_gnt", cpu_gnt, 1); finish_cycle();
        set_cpu(0, 0, 4'hF, 13'h0040, 0);
        #4;
        check("t1_rvalid", cpu_rvalid, 1);
        check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("t1_dma_rvalid", dma_rvalid, 0);
        finish_cycle();

        // Table: contention pattern and MBIST blocking.
        set_cpu(0, 0, 4'hF, 13'h0010, 0);
        set_dma(0, 0, 4'hF, 13'h0014, 0);
        for (int i = 0; i < 19; i++) begin
            cpu_req = tbl[i].c_req;
            dma_req = tbl[i].d_req;
            mbist_en = tbl[i].mbist;
            #4;
            check($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, tbl[i].e_cg);
            check($sformatf("tbl%0d_dma_gnt", i), dma_gnt, tbl[i].e_dg);
            check($sformatf("tbl%0d_starve", i), starve_evt, tbl[i].e_starve);
            finish_cycle();
        end

        // Interleaved reads.
        cpu_req = 0; dma_req = 0;
        #4; finish_cycle();
        set_cpu(1, 0, 4'hF, 13'h0000, 0);
        set_dma(1, 0, 4'hF, 13'h0004, 0);
        #4; check("il_cpu_first", cpu_gnt, 1); finish_cycle();
        cpu_req = 0;
        #4;
        check("il_dma_gnt", dma_gnt, 1);
        check("il_cpu_rvalid", cpu_rvalid, 1);
        check("il_cpu_rdata", cpu_rdata, 32'h1111_1111);
        check("il_dma_rvalid0", dma_rvalid, 0);
        finish_cycle();
        dma_req = 0;
        #4;
        check("il_dma_rvalid", dma_rvalid, 1);
        check("il_dma_rdata", dma_rdata, 32'h2222_2222);
        check("il_cpu_rvalid0", cpu_rvalid, 0);
        finish_cycle();

        // Byte lanes.
        set_dma(1, 1, 4'h2, 13'h0100, 32'hAABB_CCDD);
        #4;
        check("bl_dma_gnt", dma_gnt, 1);
        check("bl_sram_be", sram_be, 4'h2);
        finish_cycle();
        dma_req = 0;
        set_cpu(1, 0, 4'hF, 13'h0100, 0);
        #4; finish_cycle();
        cpu_req = 0;
        #4; check("bl_rdata", cpu_rdata, 32'h0000_CC00); finish_cycle();

        // Reset in the cycle after a CPU read grant.
        set_cpu(1, 0, 4'hF, 13'h0004, 0);
        set_dma(1, 0, 4'hF, 13'h0008, 0);
        #4; check("rst_rd_gnt", cpu_gnt, 1); finish_cycle();
        rst_n = 1'b0;
        #1;
        check("rst_rvalid_now", cpu_rvalid, 0);
        check_all_zero("rst_mid");
        @(posedge clk); #5;
        check_all_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        set_dma(0, 0, 4'hF, 13'h0008, 0);
        #4; check("post_rst_blocked", cpu_gnt, 0); finish_cycle();
        #4; check("post_rst_first", cpu_gnt, 1); finish_cycle();
        cpu_req = 0;
        #4; finish_cycle();

        // Random traffic with legal holding, occasional drops and mode changes.
        for (int n = 0; n < 1500; n++) begin
            if (!cpu_req || last_cg) begin
                if ($urandom_range(0, 2) != 0)
                    set_cpu(1, 1'($urandom_range(0, 1)), 4'($urandom), 13'($urandom), $urandom);
                else
                    cpu_req = 0;
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 0;
            end
            if (!dma_req || last_dg) begin
                if ($urandom_range(0, 2) != 0)
                    set_dma(1, 1'($urandom_range(0, 1)), 4'($urandom), 13'($urandom), $urandom);
                else
                    dma_req = 0;
            end else if ($urandom_range(0, 15) == 0) begin
                dma_req = 0;
            end
            mbist_en = ($urandom_range(0, 24) == 0);
            ret_en   = ($urandom_range(0, 24) == 0);
            pd_en    = ($urandom_range(0, 29) != 0);
            #4; finish_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
